// File: rtl/prefix_adder_bist.sv
// Built-in self-test driver for the 8-bit prefix adder.
// Applies directed then LFSR vectors and checks S against a golden sum.
module prefix_adder_bist #(
    parameter int          NUM_VECTORS = 64,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] adder_a,
    output logic [7:0] adder_b,
    output logic       adder_cin,
    input  logic [7:0] adder_s,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] fail_a,
    output logic [7:0] fail_b,
    output logic       fail_cin,
    output logic [7:0] fail_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A zero seed would lock the LFSR, so fall back to the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    state_t      state, state_nx;
    logic [15:0] lfsr, lfsr_nx;
    logic [15:0] vec_idx, vec_idx_nx;
    logic [7:0]  a_nx, b_nx;
    logic        cin_nx;
    logic [7:0]  err_nx;
    logic [7:0]  fa_nx, fb_nx, fs_nx;
    logic        fc_nx;

    logic [8:0]  sum9;
    logic [7:0]  golden;
    logic        mismatch;
    logic [15:0] next_idx;
    logic        lfsr_fb;

    // Golden sum is truncated: the adder has no carry-out.
    assign sum9     = {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};
    assign golden   = sum9[7:0];
    assign mismatch = (adder_s != golden);
    assign next_idx = vec_idx + 16'd1;
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 8'd0);

    // State, LFSR, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            vec_idx   <= 16'd0;
            adder_a   <= 8'd0;
            adder_b   <= 8'd0;
            adder_cin <= 1'b0;
            err_count <= 8'd0;
            fail_a    <= 8'd0;
            fail_b    <= 8'd0;
            fail_cin  <= 1'b0;
            fail_s    <= 8'd0;
        end else begin
            state     <= state_nx;
            lfsr      <= lfsr_nx;
            vec_idx   <= vec_idx_nx;
            adder_a   <= a_nx;
            adder_b   <= b_nx;
            adder_cin <= cin_nx;
            err_count <= err_nx;
            fail_a    <= fa_nx;
            fail_b    <= fb_nx;
            fail_cin  <= fc_nx;
            fail_s    <= fs_nx;
        end
    end

    // Next-state, vector generation and checking.
    always_comb begin
        state_nx   = state;
        lfsr_nx    = lfsr;
        vec_idx_nx = vec_idx;
        a_nx       = adder_a;
        b_nx       = adder_b;
        cin_nx     = adder_cin;
        err_nx     = err_count;
        fa_nx      = fail_a;
        fb_nx      = fail_b;
        fc_nx      = fail_cin;
        fs_nx      = fail_s;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx   = RUN;
                    lfsr_nx    = SEED_EFF;
                    vec_idx_nx = 16'd0;
                    a_nx       = 8'h00;
                    b_nx       = 8'h00;
                    cin_nx     = 1'b0;
                    err_nx     = 8'd0;
                    fa_nx      = 8'd0;
                    fb_nx      = 8'd0;
                    fc_nx      = 1'b0;
                    fs_nx      = 8'd0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    if (err_count != 8'hFF)
                        err_nx = err_count + 8'd1;
                    // Counter still zero means this is the first miss.
                    if (err_count == 8'd0) begin
                        fa_nx = adder_a;
                        fb_nx = adder_b;
                        fc_nx = adder_cin;
                        fs_nx = adder_s;
                    end
                end
                if (vec_idx == LAST_IDX) begin
                    state_nx = DONE;
                    a_nx     = 8'h00;
                    b_nx     = 8'h00;
                    cin_nx   = 1'b0;
                end else begin
                    vec_idx_nx = next_idx;
                    if (next_idx < 16'd4) begin
                        unique case (next_idx[1:0])
                            2'd1: begin
                                a_nx   = 8'hFF;
                                b_nx   = 8'h01;
                                cin_nx = 1'b0;
                            end
                            2'd2: begin
                                a_nx   = 8'hFF;
                                b_nx   = 8'hFF;
                                cin_nx = 1'b1;
                            end
                            2'd3: begin
                                a_nx   = 8'h80;
                                b_nx   = 8'h80;
                                cin_nx = 1'b0;
                            end
                            default: begin
                                a_nx   = 8'h00;
                                b_nx   = 8'h00;
                                cin_nx = 1'b0;
                            end
                        endcase
                    end else begin
                        // Current LFSR value is used, then it steps.
                        a_nx    = lfsr[7:0];
                        b_nx    = lfsr[15:8];
                        cin_nx  = lfsr[0] ^ lfsr[15];
                        lfsr_nx = {lfsr[14:0], lfsr_fb};
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prefix_adder_bist.sv
// Testbench for prefix_adder_bist.
// Three engines with different lengths drive a fault-injectable adder model.
module tb_prefix_adder_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start [3];
    logic [7:0] aa [3], ab [3], ss [3];
    logic       ac [3];
    logic       busy [3], done [3], pass [3];
    logic [7:0] errc [3], fa [3], fb [3], fs [3];
    logic       fc [3];

    int         mode  [3];
    logic [7:0] fmask [3];
    logic [2:0] ftrig [3];

    int          checks   = 0;
    int          failures = 0;
    logic [16:0] vec4;

    // Adder under test: 0 good, 1 S[0] stuck-0, 2 S stuck-0, 3 xor fault.
    function automatic logic [7:0] adder_model(
        input logic [7:0] a, input logic [7:0] b, input logic c,
        input int md, input logic [7:0] mask, input logic [2:0] trig);
        int s;
        logic [7:0] r;
        s = (int'(a) + int'(b) + int'(c)) % 256;
        r = 8'(s);
        case (md)
            1: r = r & 8'hFE;
            2: r = 8'h00;
            3: r = (a[2:0] == trig) ? (r ^ mask) : r;
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++)
            ss[i] = adder_model(aa[i], ab[i], ac[i], mode[i], fmask[i], ftrig[i]);
    end

    prefix_adder_bist #(.NUM_VECTORS(64), .SEED(16'hACE1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .adder_a(aa[0]), .adder_b(ab[0]), .adder_cin(ac[0]), .adder_s(ss[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .fail_a(fa[0]), .fail_b(fb[0]), .fail_cin(fc[0]), .fail_s(fs[0]));

    prefix_adder_bist #(.NUM_VECTORS(4), .SEED(16'h0000)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .adder_a(aa[1]), .adder_b(ab[1]), .adder_cin(ac[1]), .adder_s(ss[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
        .fail_a(fa[1]), .fail_b(fb[1]), .fail_cin(fc[1]), .fail_s(fs[1]));

    prefix_adder_bist #(.NUM_VECTORS(300), .SEED(16'h1234)) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .adder_a(aa[2]), .adder_b(ab[2]), .adder_cin(ac[2]), .adder_s(ss[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
        .fail_a(fa[2]), .fail_b(fb[2]), .fail_cin(fc[2]), .fail_s(fs[2]));

    function automatic int nv_of(input int i);
        return (i == 0) ? 64 : (i == 1) ? 4 : 300;
    endfunction

    function automatic logic [15:0] seed_of(input int i);
        return (i == 0) ? 16'hACE1 : (i == 1) ? 16'h0000 : 16'h1234;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Expected vector {cin, b, a} at a given index, from the vector rules.
    function automatic logic [16:0] model_vec(input int idx, input logic [15:0] seed);
        logic [15:0] l;
        case (idx)
            0: return {1'b0, 8'h00, 8'h00};
            1: return {1'b0, 8'h01, 8'hFF};
            2: return {1'b1, 8'hFF, 8'hFF};
            3: return {1'b0, 8'h80, 8'h80};
            default: ;
        endcase
        l = (seed == 16'h0) ? 16'hACE1 : seed;
        for (int k = 4; k < idx; k++) l = lfsr_step(l);
        return {l[0] ^ l[15], l[15:8], l[7:0]};
    endfunction

    function automatic logic [63:0] outs_of(input int i);
        return {11'd0, busy[i], done[i], pass[i], errc[i], fa[i], fb[i],
                fc[i], fs[i], aa[i], ab[i], ac[i]};
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%0h exp=%0h", nm, i, got, exp);
        end
    endtask

    // Scoreboard for one full run with the current fault setting.
    task automatic model_run(input int i, output int e_err,
                             output logic [24:0] e_fail);
        logic [16:0] v;
        logic [7:0]  s, g;
        e_err  = 0;
        e_fail = '0;
        for (int k = 0; k < nv_of(i); k++) begin
            v = model_vec(k, seed_of(i));
            g = 8'((int'(v[7:0]) + int'(v[15:8]) + int'(v[16])) % 256);
            s = adder_model(v[7:0], v[15:8], v[16], mode[i], fmask[i], ftrig[i]);
            if (s != g) begin
                if (e_err == 0) e_fail = {v[7:0], v[15:8], v[16], s};
                if (e_err < 255) e_err++;
            end
        end
    endtask

    task automatic run(input int i, input bit spam);
        int cyc;
        int bad_idx;
        bad_idx = -1;
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        chk("busy_after_start", i, 64'(busy[i]), 64'd1);
        chk("clear_on_start", i, {errc[i], fa[i], fb[i], fc[i], fs[i]}, 64'd0);
        cyc = 0;
        while (busy[i] && cyc < nv_of(i) + 8) begin
            if (bad_idx < 0 && {ac[i], ab[i], aa[i]} !== model_vec(cyc, seed_of(i)))
                bad_idx = cyc;
            if (cyc == 4) vec4 = {ac[i], ab[i], aa[i]};
            cyc++;
            start[i] = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start[i] = 1'b0;
        chk("busy_cycles", i, 64'(cyc), 64'(nv_of(i)));
        chk("vec_seq_first_bad", i, 64'(bad_idx), 64'(-1));
        chk("done_high", i, 64'(done[i]), 64'd1);
        chk("ops_zero_in_done", i, {aa[i], ab[i], ac[i]}, 64'd0);
    endtask

    task automatic chk_result(input int i, input int e_err, input bit e_pass,
                              input logic [24:0] e_fail);
        chk("err_count", i, 64'(errc[i]), 64'(e_err));
        chk("pass", i, 64'(pass[i]), 64'(e_pass));
        chk("fail_capture", i, {fa[i], fb[i], fc[i], fs[i]}, 64'(e_fail));
    endtask

    typedef struct {
        int          inst;
        int          md;
        int          e_err;
        bit          e_pass;
        logic [24:0] e_fail;
    } rec_t;

    rec_t recs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e_err;
        logic [24:0] e_fail;
        int          i;

        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            mode[k]  = 0;
            fmask[k] = 8'h00;
            ftrig[k] = 3'd0;
        end

        recs[0] = '{0, 0, 0,   1'b1, 25'd0};
        recs[1] = '{1, 1, 1,   1'b0, {8'hFF, 8'hFF, 1'b1, 8'hFE}};
        recs[2] = '{2, 2, 255, 1'b0, {8'hFF, 8'hFF, 1'b1, 8'h00}};
        recs[3] = '{1, 2, 1,   1'b0, {8'hFF, 8'hFF, 1'b1, 8'h00}};
        recs[4] = '{1, 0, 0,   1'b1, 25'd0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("reset_outputs", k, outs_of(k), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("idle_no_start", k, outs_of(k), 64'd0);

        // Directed table; the last entry restarts inst1 from a failing DONE.
        for (int r = 0; r < 5; r++) begin
            i = recs[r].inst;
            mode[i] = recs[r].md;
            run(i, 1'b0);
            chk_result(i, recs[r].e_err, recs[r].e_pass, recs[r].e_fail);
            if (r == 0) chk("fifth_vector", 0, 64'(vec4), {47'd0, 1'b0, 8'hAC, 8'hE1});
        end

        // start held/pulsed during RUN must be ignored.
        mode[0] = 0;
        run(0, 1'b1);
        chk_result(0, 0, 1'b1, 25'd0);

        // Asynchronous reset midway through a run.
        mode[0]  = 3;
        fmask[0] = 8'h10;
        ftrig[0] = 3'd1;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_mid_run", 0, outs_of(0), 64'd0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", 0, outs_of(0), 64'd0);
        run(0, 1'b0);
        model_run(0, e_err, e_fail);
        chk_result(0, e_err, e_err == 0, e_fail);

        // Randomized fault patterns against the scoreboard.
        for (int r = 0; r < 6; r++) begin
            i = r % 3;
            mode[i]  = 3;
            fmask[i] = 8'($urandom_range(1, 255));
            ftrig[i] = 3'($urandom_range(0, 7));
            run(i, 1'b0);
            model_run(i, e_err, e_fail);
            chk_result(i, e_err, e_err == 0, e_fail);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
